// File: rtl/dmfb_step_sequencer_if.sv
// dmfb_step_sequencer_if: move-controller, timer and electrode signals.
// Carries abort/aborted only when STEP_ABORT_EN is defined.
interface dmfb_step_sequencer_if #(
  parameter int NUM_ELEC = 4,
  parameter int STEP_W   = 8
);
  logic                stepClk;
  logic                start;
  logic                direction;
  logic [STEP_W-1:0]   stepCount;
  logic                clockControl;
  logic                timerReset;
  logic [NUM_ELEC-1:0] electrode;
  logic                busy;
  logic                done;
  logic [STEP_W-1:0]   stepsLeft;
`ifdef STEP_ABORT_EN
  logic                abort;
  logic                aborted;

  modport master (
    output stepClk, start, direction, stepCount, abort,
    input  clockControl, timerReset, electrode,
    input  busy, done, stepsLeft, aborted
  );

  modport slave (
    input  stepClk, start, direction, stepCount, abort,
    output clockControl, timerReset, electrode,
    output busy, done, stepsLeft, aborted
  );
`else
  modport master (
    output stepClk, start, direction, stepCount,
    input  clockControl, timerReset, electrode,
    input  busy, done, stepsLeft
  );

  modport slave (
    input  stepClk, start, direction, stepCount,
    output clockControl, timerReset, electrode,
    output busy, done, stepsLeft
  );
`endif
endinterface

// File: rtl/dmfb_step_sequencer.sv
// dmfb_step_sequencer: rotates the electrode pattern on each timer step.
// Define STEP_ABORT_EN to add the abort input and aborted pulse.
module dmfb_step_sequencer #(
  parameter int                  NUM_ELEC     = 4,
  parameter logic [NUM_ELEC-1:0] INIT_PATTERN = 4'b0001,
  parameter int                  STEP_W       = 8,
  parameter int                  SYNC_STAGES  = 2
) (
  input  logic                  clockIn,
  input  logic                  reset_t,
  dmfb_step_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MOVE,
    S_HOLD,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [NUM_ELEC-1:0]    elec_q, elec_d;
  logic [STEP_W-1:0]      steps_q, steps_d;
  logic                   dir_q, dir_d;
  logic                   cc_q, cc_d;
  logic                   tr_q, tr_d;
  logic                   done_q, done_d;
  logic                   abd_q, abd_d;

  logic                   step_rise;
  logic                   last_step;
  logic                   abort_req;
  logic                   in_run;
  logic [NUM_ELEC-1:0]    elec_rot;

  assign in_run = (state_q == S_MOVE) ||
                  (state_q == S_HOLD);

`ifdef STEP_ABORT_EN
  assign abort_req   = bus.abort & in_run;
  assign bus.aborted = abd_q;
`else
  assign abort_req = 1'b0;
`endif

  // A timer restart flushes the synchronizer and masks the edge so
  // that a step clock already in flight cannot count as a new step.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], bus.stepClk};
    prev_d = sync_q[SYNC_STAGES-1];
    if (tr_q) begin
      sync_d = '0;
      prev_d = 1'b0;
    end
  end

  assign step_rise = sync_q[SYNC_STAGES-1] & ~prev_q & ~tr_q;
  assign last_step = (steps_q == STEP_W'(1));

  always_comb begin
    elec_rot = elec_q;
    if (dir_q) begin
      elec_rot = {elec_q[NUM_ELEC-2:0],
                  elec_q[NUM_ELEC-1]};
    end else begin
      elec_rot = {elec_q[0],
                  elec_q[NUM_ELEC-1:1]};
    end
  end

  always_ff @(posedge clockIn) begin
    if (reset_t) begin
      state_q <= S_IDLE;
      sync_q  <= '0;
      prev_q  <= 1'b0;
      elec_q  <= INIT_PATTERN;
      steps_q <= '0;
      dir_q   <= 1'b0;
      cc_q    <= 1'b0;
      tr_q    <= 1'b0;
      done_q  <= 1'b0;
      abd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      elec_q  <= elec_d;
      steps_q <= steps_d;
      dir_q   <= dir_d;
      cc_q    <= cc_d;
      tr_q    <= tr_d;
      done_q  <= done_d;
      abd_q   <= abd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.stepCount != '0) begin
            state_d = S_MOVE;
          end else begin
            state_d = S_HOLD;
          end
        end
      end
      S_MOVE: begin
        if (abort_req) begin
          state_d = S_IDLE;
        end else if (step_rise && last_step) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (abort_req) begin
          state_d = S_IDLE;
        end else if (step_rise) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    elec_d  = elec_q;
    steps_d = steps_q;
    dir_d   = dir_q;
    cc_d    = cc_q;
    tr_d    = 1'b0;
    done_d  = 1'b0;
    abd_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cc_d = 1'b0;
        if (bus.start) begin
          dir_d   = bus.direction;
          steps_d = bus.stepCount;
          tr_d    = 1'b1;
          cc_d    = (bus.stepCount == '0);
        end
      end
      S_MOVE: begin
        cc_d = 1'b0;
        if (abort_req) begin
          steps_d = '0;
          tr_d    = 1'b1;
          abd_d   = 1'b1;
        end else if (step_rise &&
                     steps_q != '0) begin
          elec_d  = elec_rot;
          steps_d = steps_q - STEP_W'(1);
          if (last_step) begin
            cc_d = 1'b1;
            tr_d = 1'b1;
          end
        end
      end
      S_HOLD: begin
        cc_d = 1'b1;
        if (abort_req) begin
          cc_d    = 1'b0;
          steps_d = '0;
          tr_d    = 1'b1;
          abd_d   = 1'b1;
        end else if (step_rise) begin
          cc_d   = 1'b0;
          done_d = 1'b1;
        end
      end
      S_DONE: begin
        cc_d = 1'b0;
      end
      default: begin
        cc_d = 1'b0;
      end
    endcase
  end

  assign bus.clockControl = cc_q;
  assign bus.timerReset   = tr_q;
  assign bus.electrode    = elec_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.done         = done_q;
  assign bus.stepsLeft    = steps_q;

endmodule

// File: tb/tb_dmfb_step_sequencer.sv
// tb_dmfb_step_sequencer: scoreboard bench with a restartable timer model.
// Abort checks are compiled in with STEP_ABORT_EN.
module tb_dmfb_step_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic man = 1'b0;
  logic man_clk = 1'b0;
  logic tmr_clk;
  int   tcnt = 0;
  int   per;
  int   total = 0;
  int   bad = 0;

  logic [3:0] exp_e[$];
  logic [7:0] exp_s[$];

  dmfb_step_sequencer_if #(
    .NUM_ELEC(4),
    .STEP_W(8)
  ) bus ();

  dmfb_step_sequencer dut (
    .clockIn(clk),
    .reset_t(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // timer model: 10-cycle fast, 40-cycle slow, restart on timerReset
  assign per = bus.clockControl ? 40 : 10;
  assign tmr_clk = (tcnt >= per / 2);
  assign bus.stepClk = man ? man_clk : tmr_clk;

  always @(posedge clk) begin
    if (rst || bus.timerReset) tcnt <= 0;
    else if (tcnt >= per - 1) tcnt <= 0;
    else tcnt <= tcnt + 1;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive_start(input logic d,
                             input logic [7:0] c);
    @(negedge clk);
    bus.start = 1'b1;
    bus.direction = d;
    bus.stepCount = c;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b1;
    bus.stepCount = 8'd3;
    repeat (2) @(negedge clk);
    total++;
    if (bus.electrode !== 4'b0001 || bus.busy !== 1'b0 ||
        bus.done !== 1'b0 || bus.clockControl !== 1'b0 ||
        bus.timerReset !== 1'b0 || bus.stepsLeft !== 8'd0) begin
      bad++;
      $display("FAIL reset: elec=%b busy=%b done=%b cc=%b tr=%b sl=%0d",
               bus.electrode, bus.busy, bus.done,
               bus.clockControl, bus.timerReset, bus.stepsLeft);
    end
    bus.start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_start: busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_forward();
    logic [3:0] e, last;
    logic [7:0] s;
    int n, trc, dc;
    do_reset();
    exp_e = {};
    exp_s = {};
    exp_e.push_back(4'b0010); exp_s.push_back(8'd2);
    exp_e.push_back(4'b0100); exp_s.push_back(8'd1);
    exp_e.push_back(4'b1000); exp_s.push_back(8'd0);
    last = bus.electrode;
    drive_start(1'b1, 8'd3);
    total++;
    if (bus.stepsLeft !== 8'd3 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL fwd_start: sl=%0d busy=%b want 3 1",
               bus.stepsLeft, bus.busy);
    end
    n = 0; trc = 0; dc = 0;
    while (n < 600 && !(dc > 0 && !bus.busy)) begin
      if (bus.timerReset) trc++;
      if (bus.done) dc++;
      if (bus.electrode !== last) begin
        total++;
        if (exp_e.size() == 0) begin
          bad++;
          $display("FAIL fwd_extra: elec=%b want no step",
                   bus.electrode);
        end else begin
          e = exp_e.pop_front();
          s = exp_s.pop_front();
          if (bus.electrode !== e || bus.stepsLeft !== s ||
              bus.clockControl !== (s == 8'd0)) begin
            bad++;
            $display("FAIL fwd_step: elec=%b sl=%0d cc=%b want %b %0d %b",
                     bus.electrode, bus.stepsLeft,
                     bus.clockControl, e, s, (s == 8'd0));
          end
        end
        last = bus.electrode;
      end
      @(negedge clk);
      n++;
    end
    total++;
    if (exp_e.size() != 0 || trc != 2 || dc != 1) begin
      bad++;
      $display("FAIL fwd_end: left=%0d tr=%0d done=%0d want 0 2 1",
               exp_e.size(), trc, dc);
    end
    total++;
    if (bus.busy !== 1'b0 || bus.clockControl !== 1'b0 ||
        bus.stepsLeft !== 8'd0 || bus.electrode !== 4'b1000) begin
      bad++;
      $display("FAIL fwd_idle: busy=%b cc=%b sl=%0d elec=%b",
               bus.busy, bus.clockControl,
               bus.stepsLeft, bus.electrode);
    end
  endtask

  task automatic test_reverse();
    logic [3:0] e, last;
    logic [7:0] s;
    int n, dc;
    do_reset();
    exp_e = {};
    exp_s = {};
    exp_e.push_back(4'b1000); exp_s.push_back(8'd4);
    exp_e.push_back(4'b0100); exp_s.push_back(8'd3);
    exp_e.push_back(4'b0010); exp_s.push_back(8'd2);
    exp_e.push_back(4'b0001); exp_s.push_back(8'd1);
    exp_e.push_back(4'b1000); exp_s.push_back(8'd0);
    last = bus.electrode;
    drive_start(1'b0, 8'd5);
    total++;
    if (bus.stepsLeft !== 8'd5 || bus.timerReset !== 1'b1) begin
      bad++;
      $display("FAIL rev_start: sl=%0d tr=%b want 5 1",
               bus.stepsLeft, bus.timerReset);
    end
    n = 0; dc = 0;
    while (n < 800 && !(dc > 0 && !bus.busy)) begin
      if (bus.done) dc++;
      if (bus.electrode !== last) begin
        total++;
        if (exp_e.size() == 0) begin
          bad++;
          $display("FAIL rev_extra: elec=%b", bus.electrode);
        end else begin
          e = exp_e.pop_front();
          s = exp_s.pop_front();
          if (bus.electrode !== e || bus.stepsLeft !== s) begin
            bad++;
            $display("FAIL rev_step: elec=%b sl=%0d want %b %0d",
                     bus.electrode, bus.stepsLeft, e, s);
          end
        end
        last = bus.electrode;
      end
      @(negedge clk);
      n++;
    end
    total++;
    if (exp_e.size() != 0 || dc != 1 || bus.stepsLeft !== 8'd0) begin
      bad++;
      $display("FAIL rev_end: left=%0d done=%0d sl=%0d want 0 1 0",
               exp_e.size(), dc, bus.stepsLeft);
    end
  endtask

  task automatic test_zero();
    logic [3:0] e0;
    int n, dc, ec, hc;
    do_reset();
    e0 = bus.electrode;
    drive_start(1'b1, 8'd0);
    total++;
    if (bus.clockControl !== 1'b1 || bus.timerReset !== 1'b1 ||
        bus.busy !== 1'b1 || bus.stepsLeft !== 8'd0) begin
      bad++;
      $display("FAIL zero_start: cc=%b tr=%b busy=%b sl=%0d",
               bus.clockControl, bus.timerReset,
               bus.busy, bus.stepsLeft);
    end
    n = 0; dc = 0; ec = 0; hc = 0;
    while (n < 400 && !(dc > 0 && !bus.busy)) begin
      if (bus.done) dc++;
      if (bus.clockControl) hc++;
      if (bus.electrode !== e0) ec++;
      @(negedge clk);
      n++;
    end
    // slow period: rise 20 cycles after restart plus sync latency
    total++;
    if (dc != 1 || ec != 0 || hc < 20 || hc > 30) begin
      bad++;
      $display("FAIL zero_end: done=%0d chg=%0d hold=%0d want 1 0 20..30",
               dc, ec, hc);
    end
  endtask

  task automatic test_midmove();
    int n;
    do_reset();
    drive_start(1'b1, 8'd4);
    n = 0;
    while (n < 100 && bus.electrode === 4'b0001) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bus.electrode !== 4'b0010 || bus.stepsLeft !== 8'd3) begin
      bad++;
      $display("FAIL mid_step1: elec=%b sl=%0d want 0010 3",
               bus.electrode, bus.stepsLeft);
    end
    drive_start(1'b0, 8'd9);
    total++;
    if (bus.stepsLeft !== 8'd3 || bus.timerReset !== 1'b0) begin
      bad++;
      $display("FAIL mid_start: sl=%0d tr=%b want 3 0",
               bus.stepsLeft, bus.timerReset);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (bus.electrode !== 4'b0001 || bus.busy !== 1'b0 ||
        bus.stepsLeft !== 8'd0 || bus.clockControl !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: elec=%b busy=%b sl=%0d cc=%b",
               bus.electrode, bus.busy,
               bus.stepsLeft, bus.clockControl);
    end
  endtask

  task automatic test_edge_filter();
    do_reset();
    man = 1'b1;
    man_clk = 1'b0;
    repeat (4) @(negedge clk);
    drive_start(1'b1, 8'd2);
    man_clk = 1'b1;
    @(negedge clk);
    man_clk = 1'b0;
    repeat (8) @(negedge clk);
    total++;
    if (bus.electrode !== 4'b0001 || bus.stepsLeft !== 8'd2) begin
      bad++;
      $display("FAIL filt_stale: elec=%b sl=%0d want 0001 2",
               bus.electrode, bus.stepsLeft);
    end
    man_clk = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (bus.electrode !== 4'b0001) begin
      bad++;
      $display("FAIL filt_early: elec=%b want 0001", bus.electrode);
    end
    repeat (2) @(negedge clk);
    total++;
    if (bus.electrode !== 4'b0010 || bus.stepsLeft !== 8'd1) begin
      bad++;
      $display("FAIL filt_step: elec=%b sl=%0d want 0010 1",
               bus.electrode, bus.stepsLeft);
    end
    repeat (6) @(negedge clk);
    total++;
    if (bus.stepsLeft !== 8'd1) begin
      bad++;
      $display("FAIL filt_held: sl=%0d want 1", bus.stepsLeft);
    end
    man_clk = 1'b0;
    man = 1'b0;
    do_reset();
  endtask

`ifdef STEP_ABORT_EN
  task automatic test_abort();
    logic [3:0] ef;
    int n, dc;
    do_reset();
    drive_start(1'b1, 8'd4);
    n = 0;
    while (n < 200 && bus.stepsLeft !== 8'd2) begin
      @(negedge clk);
      n++;
    end
    ef = bus.electrode;
    total++;
    if (ef !== 4'b0100) begin
      bad++;
      $display("FAIL abort_pre: elec=%b want 0100", ef);
    end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    total++;
    if (bus.aborted !== 1'b1 || bus.busy !== 1'b0 ||
        bus.clockControl !== 1'b0 || bus.stepsLeft !== 8'd0 ||
        bus.timerReset !== 1'b1 || bus.electrode !== ef) begin
      bad++;
      $display("FAIL abort: ab=%b busy=%b cc=%b sl=%0d tr=%b elec=%b",
               bus.aborted, bus.busy, bus.clockControl,
               bus.stepsLeft, bus.timerReset, bus.electrode);
    end
    dc = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.done || bus.aborted || bus.electrode !== ef) dc++;
    end
    total++;
    if (dc != 0) begin
      bad++;
      $display("FAIL abort_after: events=%0d want 0", dc);
    end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    total++;
    if (bus.aborted !== 1'b0 || bus.timerReset !== 1'b0) begin
      bad++;
      $display("FAIL abort_idle: ab=%b tr=%b want 0 0",
               bus.aborted, bus.timerReset);
    end
  endtask
`endif

  initial begin
    bus.start = 1'b0;
    bus.direction = 1'b0;
    bus.stepCount = 8'd0;
`ifdef STEP_ABORT_EN
    bus.abort = 1'b0;
`endif
    test_reset();
    test_forward();
    test_reverse();
    test_zero();
    test_midmove();
    test_edge_filter();
`ifdef STEP_ABORT_EN
    test_abort();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
